stack_transfer_unit: RTL and testbench

Multi-register push/pop sequencer between the register bank and data memory. On a start pulse it walks a 16-bit register list, reading each selected register through the bank's destination-read path and storing it below the stack pointer (push), or loading words from the stack and writing them back through the bank's memory-writeback path (pop). It owns the stack-pointer arithmetic for the whole transfer and hands the final SP to the bank in one update. It sits beside the control unit and stalls the core while busy.

---
 rtl/stack_transfer_unit_pkg.sv | 28 ++
 rtl/stack_transfer_unit_reg_list_scan.sv | 35 +++
 rtl/stack_transfer_unit.sv | 164 ++++++++++++++++
 tb/tb_stack_transfer_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_transfer_unit_pkg.sv
// Shared definitions for the stack transfer unit: FSM encodings, special register indices, list helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package stack_transfer_unit_pkg;

    // FSM encoding kept as plain constants so older tools that dislike enums still read it.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_PUSH     = 3'd1;
    localparam state_t ST_POP_ADDR = 3'd2;
    localparam state_t ST_POP_DATA = 3'd3;
    localparam state_t ST_DONE     = 3'd4;

    localparam int SP_REGISTER = 14;
    localparam int PC_REGISTER = 15;

    localparam logic [31:0] MAX_NUMBER = 32'hFFFF_FFFF;

    // The SP is never part of a transfer; its final value is handed over separately.
    localparam logic [15:0] LIST_KEEP_MASK = ~(16'h0001 << SP_REGISTER);

    // One-hot mask for a register index, used to retire a list bit once transferred.
    function automatic logic [15:0] bit_mask(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/stack_transfer_unit_reg_list_scan.sv
// Finds the highest and lowest set bit of a 16-bit register list, plus an any-set flag.
// Latency: purely combinational.
// Backpressure: none; outputs are 0 when the list is empty.
//
// Ports:
//   i_list      16-bit register selection list
//   o_high_idx  index of the highest set bit
//   o_low_idx   index of the lowest set bit
//   o_any       at least one bit is set
module reg_list_scan (
    input  logic [15:0] i_list,
    output logic [3:0]  o_high_idx,
    output logic [3:0]  o_low_idx,
    output logic        o_any
);

    always_comb begin
        o_high_idx = '0;
        o_low_idx  = '0;
        o_any      = |i_list;
        // Ascending walk: the last hit wins, giving the highest set bit.
        for (int i = 0; i < 16; i++) begin
            if (i_list[i]) begin
                o_high_idx = 4'(i);
            end
        end
        // Descending walk: the last hit wins, giving the lowest set bit.
        for (int i = 15; i >= 0; i--) begin
            if (i_list[i]) begin
                o_low_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/stack_transfer_unit.sv
// Multi-register push/pop sequencer between register bank and data memory; owns SP arithmetic.
// Latency: push N regs -> done at cycle N+1; pop N regs -> done at cycle 2N+1; empty list -> cycle 1.
// Backpressure: none; core is stalled via busy, and start is ignored unless idle.
//
// Ports:
//   slow_clock, reset          core clock, async active-low reset
//   start, is_pop, reg_list,   transfer request, direction, register list, starting SP
//   sp_in
//   reg_data                   bank read of reg_index (combinational in the bank)
//   mem_read_data              memory data, valid the cycle after mem_addr
//   reg_index                  register being read (push) or written (pop)
//   mem_addr, mem_write_data,  memory port
//   mem_write_enable
//   reg_write_enable           bank writeback strobe (pop)
//   new_sp, sp_write           final SP and its one-cycle update strobe
//   busy, done                 stall indication and completion pulse
module stack_transfer_unit
    import stack_transfer_unit_pkg::*;
#(
    parameter int REGISTER_LENGTH = 32,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                       slow_clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       is_pop,
    input  logic [15:0]                reg_list,
    input  logic [REGISTER_LENGTH-1:0] sp_in,
    input  logic [REGISTER_LENGTH-1:0] reg_data,
    input  logic [REGISTER_LENGTH-1:0] mem_read_data,
    output logic [3:0]                 reg_index,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [REGISTER_LENGTH-1:0] mem_write_data,
    output logic                       mem_write_enable,
    output logic                       reg_write_enable,
    output logic [REGISTER_LENGTH-1:0] new_sp,
    output logic                       sp_write,
    output logic                       busy,
    output logic                       done
);

    localparam logic [REGISTER_LENGTH-1:0] SP_ONE = REGISTER_LENGTH'(1);

    state_t                     r_state;
    logic [15:0]                r_list;
    logic [REGISTER_LENGTH-1:0] r_sp;

    state_t                     w_state_nxt;
    logic [15:0]                w_list_nxt;
    logic [REGISTER_LENGTH-1:0] w_sp_nxt;

    logic [15:0]                w_scan_in;
    logic [3:0]                 w_high_idx;
    logic [3:0]                 w_low_idx;
    logic                       w_any;
    logic [3:0]                 w_cur_idx;
    logic [15:0]                w_list_rem;
    logic [REGISTER_LENGTH-1:0] w_sp_dec;
    logic [REGISTER_LENGTH-1:0] w_sp_inc;
    logic [REGISTER_LENGTH-1:0] w_addr_word;
    logic                       w_active;

    // Pop data bypasses this block and goes straight to the bank's writeback path.
    logic [REGISTER_LENGTH-1:0] w_unused_mem_rd;
    assign w_unused_mem_rd = mem_read_data;

    // While idle the scanner looks at the incoming list so the empty check is ready for start;
    // otherwise it scans the remaining working list.
    assign w_scan_in = (r_state == ST_IDLE) ? (reg_list & LIST_KEEP_MASK) : r_list;

    reg_list_scan u_scan (
        .i_list     (w_scan_in),
        .o_high_idx (w_high_idx),
        .o_low_idx  (w_low_idx),
        .o_any      (w_any)
    );

    // Push walks downward from the top register, pop walks upward from the bottom,
    // so the lowest register always lands at the lowest address.
    assign w_cur_idx  = (r_state == ST_PUSH) ? w_high_idx : w_low_idx;
    assign w_list_rem = r_list & ~bit_mask(w_cur_idx);
    assign w_sp_dec   = r_sp - SP_ONE;
    assign w_sp_inc   = r_sp + SP_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_list_nxt  = r_list;
        w_sp_nxt    = r_sp;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_list_nxt = w_scan_in;
                    w_sp_nxt   = sp_in;
                    if (!w_any) begin
                        w_state_nxt = ST_DONE;
                    end else if (is_pop) begin
                        w_state_nxt = ST_POP_ADDR;
                    end else begin
                        w_state_nxt = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                w_sp_nxt   = w_sp_dec;
                w_list_nxt = w_list_rem;
                if (w_list_rem == 16'h0000) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_POP_ADDR: begin
                w_state_nxt = ST_POP_DATA;
            end
            ST_POP_DATA: begin
                w_sp_nxt   = w_sp_inc;
                w_list_nxt = w_list_rem;
                w_state_nxt = (w_list_rem == 16'h0000) ? ST_DONE : ST_POP_ADDR;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_list  <= '0;
            r_sp    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_list  <= w_list_nxt;
            r_sp    <= w_sp_nxt;
        end
    end

    // Outputs decode from registered state only, so reset drops every strobe at once.
    assign w_active = (r_state == ST_PUSH) || (r_state == ST_POP_ADDR) || (r_state == ST_POP_DATA);

    // Push stores at SP-1 (pre-decrement); pop loads at SP (post-increment). The pop address
    // is held through POP_DATA so the memory sees a stable address for the whole beat.
    always_comb begin
        w_addr_word = '0;
        case (r_state)
            ST_PUSH:     w_addr_word = w_sp_dec;
            ST_POP_ADDR: w_addr_word = r_sp;
            ST_POP_DATA: w_addr_word = r_sp;
            default:     w_addr_word = '0;
        endcase
    end

    assign reg_index        = w_active ? w_cur_idx : 4'd0;
    assign mem_addr         = ADDR_WIDTH'(w_addr_word);
    assign mem_write_data   = reg_data;
    assign mem_write_enable = (r_state == ST_PUSH);
    assign reg_write_enable = (r_state == ST_POP_DATA);
    assign new_sp           = r_sp;
    assign sp_write         = (r_state == ST_DONE);
    assign done             = (r_state == ST_DONE);
    assign busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_stack_transfer_unit.sv
// Self-checking bench for stack_transfer_unit with a behavioural bank and memory.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_stack_transfer_unit;

    localparam int EV_STORE = 0;
    localparam int EV_WB    = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [3:0]  idx;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic        pop;
        logic [15:0] list;
        logic [31:0] sp;
        logic [31:0] exp_sp;
        int          exp_dcyc;
    } vec_t;

    logic        slow_clock = 1'b0;
    logic        reset      = 1'b0;
    logic        start      = 1'b0;
    logic        is_pop     = 1'b0;
    logic [15:0] reg_list   = '0;
    logic [31:0] sp_in      = '0;
    logic [31:0] reg_data;
    logic [31:0] mem_read_data = '0;
    logic [3:0]  reg_index;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic        reg_write_enable;
    logic [31:0] new_sp;
    logic        sp_write;
    logic        busy;
    logic        done;

    logic [31:0] bank [16];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    ev_t         exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 slow_clock = ~slow_clock;

    assign reg_data = bank[reg_index];

    stack_transfer_unit #(.REGISTER_LENGTH(32), .ADDR_WIDTH(32)) dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .start            (start),
        .is_pop           (is_pop),
        .reg_list         (reg_list),
        .sp_in            (sp_in),
        .reg_data         (reg_data),
        .mem_read_data    (mem_read_data),
        .reg_index        (reg_index),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .reg_write_enable (reg_write_enable),
        .new_sp           (new_sp),
        .sp_write         (sp_write),
        .busy             (busy),
        .done             (done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Drive a start request (just after a falling edge) and queue the expected strobes.
    task automatic launch(input logic pop, input logic [15:0] list, input logic [31:0] sp,
                          input logic [31:0] exp_sp, input int exp_dcyc);
        logic [15:0] l;
        logic [31:0] s;
        int          cyc;
        ev_t         e;
        l = list & 16'hBFFF;
        s = sp;
        if (!pop) begin
            cyc = 1;
            for (int i = 15; i >= 0; i--) begin
                if (l[i]) begin
                    s = s - 32'd1;
                    e = '{EV_STORE, cyc, 4'(i), s, bank[i]};
                    exp_q.push_back(e);
                    ref_mem[s] = bank[i];
                    cyc++;
                end
            end
        end else begin
            cyc = 2;
            for (int i = 0; i < 16; i++) begin
                if (l[i]) begin
                    e = '{EV_WB, cyc, 4'(i), s, ref_rd(s)};
                    exp_q.push_back(e);
                    s = s + 32'd1;
                    cyc += 2;
                end
            end
        end
        e = '{EV_DONE, exp_dcyc, 4'd0, exp_sp, 32'h0};
        exp_q.push_back(e);
        is_pop   = pop;
        reg_list = list;
        sp_in    = sp;
        start    = 1'b1;
    endtask

    // Called at each falling edge: score DUT strobes, then act as bank and memory.
    task automatic observe(input int c, output bit fin);
        ev_t e;
        bit  ok;
        fin = 1'b0;
        if (mem_write_enable) begin
            ok = (exp_q.size() != 0) && (exp_q[0].kind == EV_STORE);
            chk("store_expected", 32'(ok), 32'd1);
            if (ok) begin
                e = exp_q.pop_front();
                chk("store_cycle", 32'(c), 32'(e.cyc));
                chk("store_addr", mem_addr, e.addr);
                chk("store_data", mem_write_data, e.data);
                chk("store_index", 32'(reg_index), 32'(e.idx));
            end
            mem[mem_addr] = mem_write_data;
        end
        if (reg_write_enable) begin
            ok = (exp_q.size() != 0) && (exp_q[0].kind == EV_WB);
            chk("wb_expected", 32'(ok), 32'd1);
            if (ok) begin
                e = exp_q.pop_front();
                chk("wb_cycle", 32'(c), 32'(e.cyc));
                chk("wb_index", 32'(reg_index), 32'(e.idx));
                chk("wb_data", mem_read_data, e.data);
            end
            bank[reg_index] = mem_read_data;
        end
        mem_read_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (done) begin
            ok = (exp_q.size() != 0) && (exp_q[0].kind == EV_DONE);
            chk("done_expected", 32'(ok), 32'd1);
            if (ok) begin
                e = exp_q.pop_front();
                chk("done_cycle", 32'(c), 32'(e.cyc));
                chk("new_sp", new_sp, e.addr);
            end
            chk("sp_write_with_done", 32'(sp_write), 32'd1);
            chk("busy_with_done", 32'(busy), 32'd1);
            fin = 1'b1;
        end
    endtask

    task automatic run(input int budget, input int restart_cyc, input bit expect_done);
        bit fin;
        fin = 1'b0;
        for (int c = 1; c <= budget && !fin; c++) begin
            @(negedge slow_clock);
            observe(c, fin);
            start = (c == restart_cyc);
        end
        start = 1'b0;
        if (expect_done) begin
            chk("done_within_budget", 32'(fin), 32'd1);
            chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_we"}, 32'(mem_write_enable), 32'd0);
        chk({tag, "_reg_we"}, 32'(reg_write_enable), 32'd0);
        chk({tag, "_sp_write"}, 32'(sp_write), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b0, 16'h0007, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 4};
        vecs[1] = '{1'b1, 16'h0007, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 7};
        vecs[2] = '{1'b0, 16'h4000, 32'h0000_1234, 32'h0000_1234, 1};
        vecs[3] = '{1'b1, 16'h4000, 32'h0000_0055, 32'h0000_0055, 1};
        vecs[4] = '{1'b0, 16'h8001, 32'h0000_0001, 32'hFFFF_FFFF, 3};
        vecs[5] = '{1'b1, 16'h8001, 32'hFFFF_FFFF, 32'h0000_0001, 5};
        vecs[6] = '{1'b0, 16'hC0F0, 32'h0000_1000, 32'h0000_0FFB, 6};
        vecs[7] = '{1'b1, 16'hC0F0, 32'h0000_0FFB, 32'h0000_1000, 11};

        for (int i = 0; i < 16; i++) begin
            bank[i] = 32'd10 + 32'(i);
        end

        // Reset values
        #2;
        chk("rst_reg_index", 32'(reg_index), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_new_sp", new_sp, 32'd0);
        chk_quiet("rst");
        @(negedge slow_clock);
        @(negedge slow_clock);
        reset = 1'b1;
        @(negedge slow_clock);

        // Table-driven transfers
        for (int v = 0; v < 8; v++) begin
            launch(vecs[v].pop, vecs[v].list, vecs[v].sp, vecs[v].exp_sp, vecs[v].exp_dcyc);
            run(40, 0, 1'b1);
            @(negedge slow_clock);
            chk_quiet("after_vec");
        end
        chk("pop_restored_r15", bank[15], 32'd25);
        chk("pop_restored_r2", bank[2], 32'd12);

        // Reset in cycle 2 of a 4-register push
        launch(1'b0, 16'h000F, 32'h0000_0200, 32'h0000_01FC, 5);
        run(2, 0, 1'b0);
        reset = 1'b0;
        #1;
        chk("arst_reg_index", 32'(reg_index), 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk_quiet("arst");
        exp_q.delete();
        @(negedge slow_clock);
        chk_quiet("arst_hold");
        reset = 1'b1;
        @(negedge slow_clock);
        chk_quiet("arst_release");
        launch(1'b0, 16'h0003, 32'h0000_0300, 32'h0000_02FE, 3);
        run(40, 0, 1'b1);

        // Second start while busy is ignored: one done, then idle
        @(negedge slow_clock);
        launch(1'b0, 16'h0030, 32'h0000_0400, 32'h0000_03FE, 3);
        run(40, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge slow_clock);
            chk_quiet("no_restart");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
